irencoder_wb8: RTL
==================

// Module: irencoder_wb8
// PURPOSE
//  Wishbone (8-bit) NEC infrared transmitter; the transmit-side counterpart of irdecoder_wb8.
//  Mapped by the top-level bus arbiter as a peripheral; the CPU loads address/command bytes and starts a frame.
//  Generates a 38 kHz-modulated NEC frame on an IR LED pin.
// PARAMETERS
//  CLOCKFREQ   25125000  system clock in Hz
//  CARRIER_HZ  38000     carrier frequency in Hz
// PORTS
//  I_wb_clk      in   1  system clock; all logic on rising edge
//  I_reset       in   1  reset, asynchronous, active-high
//  I_wb_adr      in   2  register select
//  I_wb_dat      in   8  write data
//  I_wb_stb      in   1  strobe
//  I_wb_we       in   1  write enable
//  O_wb_dat      out  8  read data
//  O_wb_ack      out  1  acknowledge
//  O_ir_led      out  1  modulated output (1 = LED on)
//  O_ir_envelope out  1  unmodulated mark/space envelope (debug)
// BEHAVIOUR
//  Derived constants:
//  - UNIT = CLOCKFREQ*9/16000 cycles (562.5 us); HALF = CLOCKFREQ/(2*CARRIER_HZ) cycles.
//  - Counter widths: $clog2 of each constant. All division is integer, truncating.
//  Registers:
//  - 0: ADDR (r/w).  1: CMD (r/w).
//  - 2: CTRL. Write bit0=1 -> start. Read: bit0 = busy, bits[7:1] = 0.
//  - 3: reads 0x00; writes ignored.
//  Bus handshake:
//  - O_wb_ack <= I_wb_stb every clock; latency is 1 cycle, and ack stays high while stb is held.
//  - Reads: O_wb_dat registered on the same cycle as ack. Writes take effect on the stb cycle.
//  Reset values:
//  - ADDR=CMD=0; O_wb_ack=0; O_wb_dat=0; O_ir_led=0; O_ir_envelope=0; state IDLE; all counters 0.
//  Start:
//  - Start in IDLE latches shift = {~CMD, CMD, ~ADDR, ADDR}; bits go out LSB first (ADDR bit0 first).
//  - Start while busy is ignored.
//  - ADDR/CMD writes during a frame are allowed and do not affect the frame in flight.
//  State machine (durations in UNIT; unit counter restarts on each state entry):
//  - IDLE -> LEAD_MARK(16) -> LEAD_SPACE(8) -> BIT_MARK(1) -> BIT_SPACE(1 if bit=0, 3 if bit=1).
//  - After BIT_SPACE: back to BIT_MARK until 32 bits are sent, then STOP_MARK(1) -> IDLE.
//  Outputs and timing:
//  - busy = (state != IDLE). Envelope = 1 in *_MARK states, else 0.
//  - O_ir_led = envelope & carrier. Carrier toggles every HALF cycles.
//  - Carrier counter and phase reset at every mark entry, so each mark starts with a full high half-period.
//  - First envelope high appears 1 cycle after the start-write cycle. busy falls in the cycle STOP_MARK ends.
//  Reset mid-frame: outputs drop to 0 immediately (async); frame is abandoned, nothing resumes after reset.
// CONFIGURATION
//  IRENCODER_REPEAT_EN defined:
//  - CTRL write bit1=1 (IDLE only) sends an NEC repeat code: LEAD_MARK(16) -> REP_SPACE(4) -> STOP_MARK(1) -> IDLE.
//  - bit0 and bit1 written together: bit0 wins.
//  IRENCODER_REPEAT_EN undefined:
//  - bit1 is ignored and the REP_SPACE state does not exist.
// TESTING  (CLOCKFREQ=1600000, CARRIER_HZ=38000 -> UNIT=900, HALF=21)
//  1. Reset, read regs 0..3 -> 0x00 each; ack exactly 1 cycle after stb; O_ir_led=0.
//  2. Write ADDR=0x04, CMD=0x08, CTRL=0x01 -> envelope 16u mark, 8u space.
//     Bytes 04,FB,08,F7 sent LSB first (16 ones, 16 zeros); stop mark.
//     busy high for exactly 121*900 cycles.
//  3. During test 2: O_ir_led toggles every 21 cycles inside marks, stays 0 in spaces, high at each mark start.
//  4. Mid-frame CTRL=0x01 and ADDR=0xFF writes -> frame unchanged.
//     Next start sends 0xFF/0x00 address bytes.
//  5. Assert I_reset asynchronously mid BIT_MARK -> O_ir_led, O_ir_envelope, status 0 at once.
//     After release, no output until a new start.
//  6. REPEAT_EN: CTRL=0x02 -> 16u mark, 4u space, 1u mark, busy 21*900 cycles.
//     Without REPEAT_EN: CTRL=0x02 -> no output, busy stays 0.

Source files
------------

// File: rtl/irencoder_wb8.sv
// -----------------------------------------------------------------------------
// irencoder_wb8 -- Wishbone (8-bit) NEC infrared transmitter.
//
// The CPU loads an address byte and a command byte, then writes CTRL bit0 to
// send one NEC frame: 16-unit lead mark, 8-unit lead space, 32 data bits
// (ADDR, ~ADDR, CMD, ~CMD, LSB first; each bit is a 1-unit mark followed by a
// 1-unit space for '0' or a 3-unit space for '1'), then a 1-unit stop mark.
// Marks are modulated with a square-wave carrier on O_ir_led.
//
// Optional feature (compile-time macro IRENCODER_REPEAT_EN):
//   CTRL bit1 written while idle sends an NEC repeat code
//   (16-unit mark, 4-unit space, 1-unit mark). bit0 has priority over bit1.
//   Without the macro bit1 is ignored.
//
// Parameters:
//   CLOCKFREQ   system clock in Hz
//   CARRIER_HZ  carrier frequency in Hz
//
// Ports:
//   I_wb_clk       system clock, rising edge
//   I_reset        asynchronous active-high reset
//   I_wb_adr[1:0]  register select: 0 ADDR, 1 CMD, 2 CTRL/status, 3 reserved
//   I_wb_dat[7:0]  write data
//   I_wb_stb       strobe
//   I_wb_we        write enable
//   O_wb_dat[7:0]  registered read data
//   O_wb_ack       acknowledge
//   O_ir_led       modulated IR output (1 = LED on)
//   O_ir_envelope  unmodulated mark/space envelope
//   O_dbg_state    current FSM state (0 = IDLE, 1 LEAD_MARK, 2 LEAD_SPACE,
//                  3 BIT_MARK, 4 BIT_SPACE, 5 STOP_MARK, 6 REP_SPACE)
//
// Bus handshake: every clock O_wb_ack takes the value of I_wb_stb, so an access
// is acknowledged one cycle after stb and ack stays high while stb is held.
// A write takes effect at the clock edge that samples stb; read data is
// registered at that same edge and is valid while ack is high.
// -----------------------------------------------------------------------------
module irencoder_wb8 #(
    parameter int CLOCKFREQ  = 25125000,
    parameter int CARRIER_HZ = 38000
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [1:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic [7:0] O_wb_dat,
    output logic       O_wb_ack,
    output logic       O_ir_led,
    output logic       O_ir_envelope,
    output logic [2:0] O_dbg_state
);

    // 562.5 us NEC time unit and carrier half-period, in clock cycles.
    localparam int UNIT   = CLOCKFREQ * 9 / 16000;
    localparam int HALF   = CLOCKFREQ / (2 * CARRIER_HZ);
    localparam int UNIT_W = (UNIT > 1) ? $clog2(UNIT) : 1;
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP_MARK  = 3'd5
`ifdef IRENCODER_REPEAT_EN
        , S_REP_SPACE = 3'd6
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [7:0]          r_addr;
    logic [7:0]          r_cmd;
    logic [7:0]          r_dat;
    logic                r_ack;
    logic [31:0]         r_shift;
    logic [4:0]          r_bit_cnt;
    logic [UNIT_W-1:0]   r_cyc_cnt;
    logic [4:0]          r_unit_cnt;
    logic [HALF_W-1:0]   r_half_cnt;
    logic                r_carrier;
`ifdef IRENCODER_REPEAT_EN
    logic                r_rep;
    logic                w_rep_start;
`endif

    logic                w_ctrl_wr;
    logic                w_start;
    logic                w_busy;
    logic                w_env;
    logic                w_next_is_mark;
    logic                w_state_change;
    logic                w_mark_entry;
    logic                w_unit_end;
    logic                w_state_end;
    logic [4:0]          w_dur;
    logic [7:0]          w_rd_data;

    assign w_ctrl_wr = I_wb_stb && I_wb_we && (I_wb_adr == 2'd2);
    assign w_start   = w_ctrl_wr && I_wb_dat[0];
`ifdef IRENCODER_REPEAT_EN
    // bit0 wins when both start bits are written together.
    assign w_rep_start = w_ctrl_wr && !I_wb_dat[0] && I_wb_dat[1];
`endif

    assign w_busy = (r_state != S_IDLE);
    assign w_env  = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) ||
                    (r_state == S_STOP_MARK);
    assign w_next_is_mark = (w_next_state == S_LEAD_MARK) ||
                            (w_next_state == S_BIT_MARK) ||
                            (w_next_state == S_STOP_MARK);
    assign w_state_change = (w_next_state != r_state);
    assign w_mark_entry   = w_state_change && w_next_is_mark;

    // Length of the current state in units; the bit being sent is r_shift[0].
    always_comb begin
        w_dur = 5'd1;
        case (r_state)
            S_LEAD_MARK:  w_dur = 5'd16;
            S_LEAD_SPACE: w_dur = 5'd8;
            S_BIT_SPACE:  w_dur = r_shift[0] ? 5'd3 : 5'd1;
`ifdef IRENCODER_REPEAT_EN
            S_REP_SPACE:  w_dur = 5'd4;
`endif
            default:      w_dur = 5'd1;
        endcase
    end

    assign w_unit_end  = (r_cyc_cnt == UNIT_LAST);
    assign w_state_end = w_unit_end && (r_unit_cnt == (w_dur - 5'd1));

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_LEAD_MARK;
                end
`ifdef IRENCODER_REPEAT_EN
                else if (w_rep_start) begin
                    w_next_state = S_LEAD_MARK;
                end
`endif
            end
            S_LEAD_MARK: begin
                if (w_state_end) begin
                    w_next_state = S_LEAD_SPACE;
`ifdef IRENCODER_REPEAT_EN
                    if (r_rep) begin
                        w_next_state = S_REP_SPACE;
                    end
`endif
                end
            end
            S_LEAD_SPACE: begin
                if (w_state_end) w_next_state = S_BIT_MARK;
            end
            S_BIT_MARK: begin
                if (w_state_end) w_next_state = S_BIT_SPACE;
            end
            S_BIT_SPACE: begin
                if (w_state_end) begin
                    w_next_state = (r_bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK: begin
                if (w_state_end) w_next_state = S_IDLE;
            end
`ifdef IRENCODER_REPEAT_EN
            S_REP_SPACE: begin
                if (w_state_end) w_next_state = S_STOP_MARK;
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (I_wb_adr)
            2'd0:    w_rd_data = r_addr;
            2'd1:    w_rd_data = r_cmd;
            2'd2:    w_rd_data = {7'd0, w_busy};
            default: w_rd_data = 8'h00;
        endcase
    end

    // Bus registers.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            r_addr <= 8'h00;
            r_cmd  <= 8'h00;
            r_dat  <= 8'h00;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= I_wb_stb;
            if (I_wb_stb && !I_wb_we) begin
                r_dat <= w_rd_data;
            end
            if (I_wb_stb && I_wb_we) begin
                if (I_wb_adr == 2'd0) r_addr <= I_wb_dat;
                if (I_wb_adr == 2'd1) r_cmd  <= I_wb_dat;
            end
        end
    end

    // Frame datapath: shift register, timing counters and carrier.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            r_shift    <= 32'd0;
            r_bit_cnt  <= 5'd0;
            r_cyc_cnt  <= '0;
            r_unit_cnt <= 5'd0;
            r_half_cnt <= '0;
            r_carrier  <= 1'b0;
`ifdef IRENCODER_REPEAT_EN
            r_rep      <= 1'b0;
`endif
        end else begin
            // The frame word is captured once, so ADDR/CMD writes during a
            // frame only affect the next one.
            if ((r_state == S_IDLE) && w_start) begin
                r_shift   <= {~r_cmd, r_cmd, ~r_addr, r_addr};
                r_bit_cnt <= 5'd0;
`ifdef IRENCODER_REPEAT_EN
                r_rep     <= 1'b0;
            end else if ((r_state == S_IDLE) && w_rep_start) begin
                r_rep     <= 1'b1;
`endif
            end else if ((r_state == S_BIT_SPACE) && w_state_end) begin
                r_shift   <= {1'b0, r_shift[31:1]};
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end

            // Unit timing restarts on every state entry.
            if (w_state_change) begin
                r_cyc_cnt  <= '0;
                r_unit_cnt <= 5'd0;
            end else if (w_busy) begin
                if (w_unit_end) begin
                    r_cyc_cnt  <= '0;
                    r_unit_cnt <= r_unit_cnt + 5'd1;
                end else begin
                    r_cyc_cnt <= r_cyc_cnt + 1'b1;
                end
            end

            // Carrier phase is re-armed high at every mark entry so each
            // mark begins with a full high half-period.
            if (w_mark_entry) begin
                r_half_cnt <= '0;
                r_carrier  <= 1'b1;
            end else if (w_env) begin
                if (r_half_cnt == HALF_LAST) begin
                    r_half_cnt <= '0;
                    r_carrier  <= ~r_carrier;
                end else begin
                    r_half_cnt <= r_half_cnt + 1'b1;
                end
            end else begin
                r_half_cnt <= '0;
                r_carrier  <= 1'b0;
            end
        end
    end

    assign O_wb_dat      = r_dat;
    assign O_wb_ack      = r_ack;
    assign O_ir_envelope = w_env;
    assign O_ir_led      = w_env && r_carrier;
    assign O_dbg_state   = r_state;

endmodule
